// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the InvMixColumns engine.
package aes_pkg;

  typedef logic [7:0]       aes_byte_t;
  typedef aes_byte_t [3:0]  aes_col_t;
  typedef aes_col_t [3:0]   aes_state_t;

  localparam aes_byte_t AES_POLY = 8'h1B;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic aes_byte_t xtime(input aes_byte_t a);
    aes_byte_t red;
    red   = a[7] ? AES_POLY : 8'h00;
    xtime = {a[6:0], 1'b0} ^ red;
  endfunction

endpackage

// File: rtl/inv_mix_column_core.sv
// Combinational (Inv)MixColumns of one column; forward mode exists only with
// INV_MIX_COLUMNS_FWD_MODE_EN defined.
module inv_mix_column_core
  import aes_pkg::*;
(
  input  aes_col_t col,
`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
  input  logic     fwd_mode,
`endif
  output aes_col_t result
);

  aes_col_t x2_s;
  aes_col_t x4_s;
  aes_col_t x8_s;
  aes_col_t m9_s;
  aes_col_t mb_s;
  aes_col_t md_s;
  aes_col_t me_s;

  // Chained xtime products; every inverse coefficient is a sum of x8/x4/x2/a.
  always_comb begin
    x2_s = '0;
    x4_s = '0;
    x8_s = '0;
    m9_s = '0;
    mb_s = '0;
    md_s = '0;
    me_s = '0;
    for (int j = 0; j < 4; j++) begin
      x2_s[j] = xtime(col[j]);
      x4_s[j] = xtime(x2_s[j]);
      x8_s[j] = xtime(x4_s[j]);
      m9_s[j] = x8_s[j] ^ col[j];
      mb_s[j] = x8_s[j] ^ x2_s[j] ^ col[j];
      md_s[j] = x8_s[j] ^ x4_s[j] ^ col[j];
      me_s[j] = x8_s[j] ^ x4_s[j] ^ x2_s[j];
    end
  end

  // Byte j mixes with j-1, j-2, j-3 (mod 4); lower byte index = higher AES row.
  always_comb begin
    result = '0;
    for (int j = 0; j < 4; j++) begin
`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
      if (fwd_mode) begin
        result[j] = x2_s[j] ^ x2_s[(j + 3) % 4] ^ col[(j + 3) % 4]
                  ^ col[(j + 2) % 4] ^ col[(j + 1) % 4];
      end else begin
        result[j] = me_s[j] ^ mb_s[(j + 3) % 4] ^ md_s[(j + 2) % 4]
                  ^ m9_s[(j + 1) % 4];
      end
`else
      result[j] = me_s[j] ^ mb_s[(j + 3) % 4] ^ md_s[(j + 2) % 4]
                ^ m9_s[(j + 1) % 4];
`endif
    end
  end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative InvMixColumns engine, COLS_PER_CYCLE columns per clock, one-entry
// result buffer. Optional forward mode under INV_MIX_COLUMNS_FWD_MODE_EN.
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t in_state,
  output logic       out_valid,
  input  logic       out_ready,
`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
  input  logic       fwd_mode,
`endif
  output aes_state_t out_state
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A 2-bit counter wraps to 0 exactly when the last group is written.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [1:0] cnt_r;
  logic [1:0] cnt_nxt_s;
  aes_state_t work_r;
  aes_state_t work_nxt_s;
  aes_state_t busy_work_s;
  logic       in_ready_r;
  logic       out_valid_r;
  logic       accept_s;

  aes_col_t   core_in_s  [COLS_PER_CYCLE];
  aes_col_t   core_out_s [COLS_PER_CYCLE];

`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
  logic       fwd_r;
`endif

  assign accept_s = in_valid && in_ready_r;

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_core
    assign core_in_s[k] = work_r[cnt_r + 2'(k)];

    inv_mix_column_core u_core (
      .col      (core_in_s[k]),
`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
      .fwd_mode (fwd_r),
`endif
      .result   (core_out_s[k])
    );
  end

  // Write the transformed columns back in place over the work register.
  always_comb begin
    busy_work_s = work_r;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      busy_work_s[cnt_r + 2'(k)] = core_out_s[k];
    end
  end

  // Next-state, counter and work-register update.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    work_nxt_s  = work_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_BUSY;
          cnt_nxt_s   = 2'd0;
          work_nxt_s  = in_state;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        work_nxt_s = busy_work_s;
        cnt_nxt_s  = cnt_r + CNT_STEP;
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 2'd0;
        work_nxt_s  = '0;
      end
    endcase
  end

  // State registers; handshake outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 2'd0;
      work_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      work_r      <= work_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
    end
  end

`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
  // Mode is frozen at acceptance so it cannot change mid-transform.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_r <= 1'b0;
    end else if (accept_s) begin
      fwd_r <= fwd_mode;
    end else begin
      fwd_r <= fwd_r;
    end
  end
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_state = work_r;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Self-checking bench: three engines (COLS_PER_CYCLE = 1, 2, 4) against a GF(2^8) matrix model.
module tb_inv_mix_columns_iter;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic       out_valid [3];
  logic       out_ready [3];
  aes_state_t in_state  [3];
  aes_state_t out_state [3];
`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
  logic       fwd_mode  [3];
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CPC = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    inv_mix_columns_iter #(.COLS_PER_CYCLE(CPC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
      .fwd_mode  (fwd_mode[g]),
`endif
      .out_state (out_state[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Shift-and-add GF(2^8) multiply, independent of the RTL's xtime chain.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product in AES row order; row r lives in byte 3-r.
  function automatic aes_state_t ref_state(input aes_state_t s, input bit fwd);
    logic [7:0] coef [4];
    logic [7:0] a [4];
    logic [7:0] acc;
    aes_state_t r;
    if (fwd) coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    else     coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) a[row] = s[c][3 - row];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[k], a[(row + k) % 4]);
        r[c][3 - row] = acc;
      end
    end
    return r;
  endfunction

  function automatic int cpc_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  function automatic aes_state_t rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One transaction: accept, measure latency, hold in DONE, drain. Called at posedge+1.
  task automatic run_txn(input int d, input aes_state_t s, input bit fwd, input int hold,
                         input bit poke, output aes_state_t res);
    aes_state_t exp;
    aes_state_t snap;
    int lat;
    exp = ref_state(s, fwd);
    check($sformatf("idle_ready_d%0d", d), in_ready[d], 1'b1);
    in_valid[d] = 1'b1;
    in_state[d] = s;
`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
    fwd_mode[d] = fwd;
`endif
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_state[d] = rand_state();
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid[d]) check($sformatf("busy_ready_d%0d", d), in_ready[d], 1'b0);
    end while (!out_valid[d] && lat < 20);
    check($sformatf("latency_d%0d", d), lat, 4 / cpc_of(d));
    check($sformatf("result_d%0d", d), out_state[d], exp);
    snap = out_state[d];
    res = snap;
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 3) begin
        in_valid[d] = 1'b1;
        in_state[d] = ~s;
      end else begin
        in_valid[d] = 1'b0;
      end
      @(posedge clk); #1;
      check($sformatf("hold_valid_d%0d", d), out_valid[d], 1'b1);
      check($sformatf("hold_ready_d%0d", d), in_ready[d], 1'b0);
      check($sformatf("hold_state_d%0d", d), out_state[d], snap);
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    check($sformatf("drain_valid_d%0d", d), out_valid[d], 1'b0);
    check($sformatf("drain_ready_d%0d", d), in_ready[d], 1'b1);
  endtask

  // in_valid held high over three states with out_ready held high.
  task automatic run_b2b(input int d);
    aes_state_t src [3];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic rdy;
    logic ov;
    aes_state_t os;
    for (int i = 0; i < 3; i++) src[i] = rand_state();
    out_ready[d] = 1'b1;
    while (got < 3 && cyc < 100) begin
      if (sent < 3) begin
        in_valid[d] = 1'b1;
        in_state[d] = src[sent];
      end else begin
        in_valid[d] = 1'b0;
      end
      rdy = in_ready[d];
      ov  = out_valid[d];
      os  = out_state[d];
      @(posedge clk); #1;
      cyc++;
      if (ov) begin
        check($sformatf("b2b_result%0d_d%0d", got, d), os, ref_state(src[got], 1'b0));
        got++;
      end
      if (rdy && in_valid[d] && sent < 3) sent++;
    end
    check($sformatf("b2b_count_d%0d", d), got, 3);
    in_valid[d] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_no_dup_d%0d", d), out_valid[d], 1'b0);
    end
    out_ready[d] = 1'b0;
  endtask

  initial begin
    aes_state_t res;
    aes_state_t res2;
    aes_state_t orig;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b0;
      in_state[d] = '0;
`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
      fwd_mode[d] = 1'b0;
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_in_ready_d%0d", d), in_ready[d], 1'b1);
      check($sformatf("rst_out_valid_d%0d", d), out_valid[d], 1'b0);
      check($sformatf("rst_out_state_d%0d", d), out_state[d], 128'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 3; d++) begin
      run_txn(d, 128'h00000000_00000000_00000000_8e4da1bc, 1'b0, 0, 1'b0, res);
      check($sformatf("vec1_const_d%0d", d), res, 128'h00000000_00000000_00000000_db135345);
      // Inverse of 4d7ebdf8 is 2d26314c (4d7ebdf8 is MixColumns of 2d26314c).
      run_txn(d, 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6, 1'b0, 10, 1'b1, res);
      check($sformatf("vec2_const_d%0d", d), res, 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6);
      for (int i = 0; i < 4; i++) begin
        run_txn(d, rand_state(), 1'b0, $urandom_range(0, 3), 1'b0, res);
      end
      run_b2b(d);
    end

    // Abort mid-transform after two columns on the 1- and 2-column engines.
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b1;
      in_state[d] = rand_state();
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      repeat (2 / cpc_of(d)) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check($sformatf("abort_valid_d%0d", d), out_valid[d], 1'b0);
      check($sformatf("abort_ready_d%0d", d), in_ready[d], 1'b1);
      check($sformatf("abort_state_d%0d", d), out_state[d], 128'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) begin
        @(posedge clk); #1;
        check($sformatf("abort_quiet_d%0d", d), out_valid[d], 1'b0);
      end
      run_txn(d, rand_state(), 1'b0, 1, 1'b0, res);
    end

`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
    for (int d = 0; d < 3; d++) begin
      run_txn(d, 128'h00000000_00000000_00000000_db135345, 1'b1, 0, 1'b0, res);
      check($sformatf("fwd_const_d%0d", d), res, 128'h00000000_00000000_00000000_8e4da1bc);
      for (int i = 0; i < 3; i++) begin
        orig = rand_state();
        run_txn(d, orig, 1'b1, 0, 1'b0, res);
        run_txn(d, res, 1'b0, 0, 1'b0, res2);
        check($sformatf("roundtrip_d%0d", d), res2, orig);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
